fixed_div: RTL and testbench

//  Fully pipelined signed fixed-point divider: q = (a << SCALE) / b, one op per clock.

---
 rtl/fixed_div.sv | 171 +++++++++++++++++
 tb/tb_fixed_div.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fixed_div.sv
// fixed_div: fully pipelined signed fixed-point divider, q = (a << SCALE) / b.
// One operation accepted per clock, no stall; results emerge exactly LAT clocks after
// the input is sampled. Quotients truncate toward zero; divide-by-zero and overflow
// saturate to the format limits and raise o_dz / o_ovf.
//
// Ports
//   clk      in   clock, all state on rising edge
//   reset_l  in   asynchronous active-low reset, clears every pipeline stage
//   i_valid  in   a/b valid this cycle
//   a        in   dividend, signed fixed point (SCALE fractional bits)
//   b        in   divisor, signed fixed point (SCALE fractional bits)
//   o_valid  out  q/flags valid this cycle (i_valid delayed LAT)
//   q        out  quotient, signed fixed point
//   o_dz     out  divide-by-zero for this result
//   o_ovf    out  quotient saturated
//
// Pipeline: stage 0 registers sign/magnitudes, LAT-2 core stages run a restoring
// divide K steps each, the output stage applies sign and saturation.
module fixed_div #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SCALE = 16,
  parameter int unsigned LAT   = 18
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             o_valid,
  output logic [WIDTH-1:0] q,
  output logic             o_dz,
  output logic             o_ovf
);

  localparam int unsigned QB    = WIDTH + SCALE;
  localparam int unsigned NCORE = LAT - 2;
  localparam int unsigned K     = (QB + NCORE - 1) / NCORE;

  localparam logic [WIDTH-1:0] QMAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] QMIN    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [QB-1:0]    MAG_MIN = QB'(1) << (WIDTH - 1);
  localparam logic [QB-1:0]    MAG_MAX = MAG_MIN - QB'(1);

  // Index 0 is the input stage, 1..NCORE are the core stages.
  logic             vld_q  [0:NCORE];
  logic             sign_q [0:NCORE];
  logic             dz_q   [0:NCORE];
  logic             aneg_q [0:NCORE];
  // Numerator bits still to consume sit in the top of nq, quotient bits fill from the
  // bottom; after QB steps nq holds the full quotient magnitude.
  logic [QB-1:0]    nq_q   [0:NCORE];
  logic [WIDTH:0]   rem_q  [0:NCORE];
  logic [WIDTH:0]   den_q  [0:NCORE];

  logic [QB-1:0]    nq_d   [1:NCORE];
  logic [WIDTH:0]   rem_d  [1:NCORE];

  // ---------------------------------------------------------------------------
  // Stage 0: magnitudes, one bit wider so |most-negative| is exact
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]  ext_a, ext_b, abs_a, abs_b;
  logic [QB-1:0]   nq0;

  always_comb begin
    ext_a = {a[WIDTH-1], a};
    ext_b = {b[WIDTH-1], b};
    abs_a = ext_a[WIDTH] ? (~ext_a + 1'b1) : ext_a;
    abs_b = ext_b[WIDTH] ? (~ext_b + 1'b1) : ext_b;
    nq0   = QB'(abs_a) << SCALE;
  end

  // ---------------------------------------------------------------------------
  // Core: restoring division, K steps per stage (last stage may do fewer)
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] step_r, step_t;
  logic [QB-1:0]  step_n;

  always_comb begin
    step_r = '0;
    step_t = '0;
    step_n = '0;
    for (int s = 1; s <= int'(NCORE); s++) begin
      step_r = rem_q[s-1];
      step_n = nq_q[s-1];
      for (int j = 0; j < int'(K); j++) begin
        if ((s - 1) * int'(K) + j < int'(QB)) begin
          // Partial remainder stays below the divisor, so its top bit is always clear.
          step_t = {step_r[WIDTH-1:0], step_n[QB-1]};
          step_n = step_n << 1;
          if (step_t >= den_q[s-1]) begin
            step_t    = step_t - den_q[s-1];
            step_n[0] = 1'b1;
          end
          step_r = step_t;
        end
      end
      rem_d[s] = step_r;
      nq_d[s]  = step_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: sign, divide-by-zero and saturation
  // ---------------------------------------------------------------------------
  logic [QB-1:0]    mag;
  logic [WIDTH-1:0] q_d;
  logic             dz_d, ovf_d;

  always_comb begin
    mag   = nq_q[NCORE];
    q_d   = mag[WIDTH-1:0];
    dz_d  = 1'b0;
    ovf_d = 1'b0;
    if (dz_q[NCORE]) begin
      // 0/0 has a non-negative dividend and so lands on MAX.
      q_d  = aneg_q[NCORE] ? QMIN : QMAX;
      dz_d = 1'b1;
    end else if (!sign_q[NCORE] && (mag > MAG_MAX)) begin
      q_d   = QMAX;
      ovf_d = 1'b1;
    end else if (sign_q[NCORE] && (mag > MAG_MIN)) begin
      q_d   = QMIN;
      ovf_d = 1'b1;
    end else if (sign_q[NCORE]) begin
      q_d = '0 - mag[WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int s = 0; s <= int'(NCORE); s++) begin
        vld_q[s]  <= 1'b0;
        sign_q[s] <= 1'b0;
        dz_q[s]   <= 1'b0;
        aneg_q[s] <= 1'b0;
        nq_q[s]   <= '0;
        rem_q[s]  <= '0;
        den_q[s]  <= '0;
      end
      o_valid <= 1'b0;
      q       <= '0;
      o_dz    <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      vld_q[0]  <= i_valid;
      sign_q[0] <= a[WIDTH-1] ^ b[WIDTH-1];
      dz_q[0]   <= (b == '0);
      aneg_q[0] <= a[WIDTH-1];
      nq_q[0]   <= nq0;
      rem_q[0]  <= '0;
      den_q[0]  <= abs_b;
      for (int s = 1; s <= int'(NCORE); s++) begin
        vld_q[s]  <= vld_q[s-1];
        sign_q[s] <= sign_q[s-1];
        dz_q[s]   <= dz_q[s-1];
        aneg_q[s] <= aneg_q[s-1];
        nq_q[s]   <= nq_d[s];
        rem_q[s]  <= rem_d[s];
        den_q[s]  <= den_q[s-1];
      end
      o_valid <= vld_q[NCORE];
      q       <= q_d;
      o_dz    <= dz_d;
      o_ovf   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fixed_div.sv
// Bench for fixed_div (WIDTH=32, SCALE=16, LAT=18): directed vectors with hand-computed
// quotients, a random stream against a 64-bit integer reference, and an in-flight reset.
module tb_fixed_div;

  localparam int L  = 18;
  localparam int HN = 4096;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        i_valid;
  logic [31:0] a, b;
  logic        o_valid;
  logic [31:0] q;
  logic        o_dz, o_ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected result for the input driven in cycle slot c.
  bit          hv   [0:HN-1];
  logic [31:0] hq   [0:HN-1];
  bit          hdz  [0:HN-1];
  bit          hovf [0:HN-1];

  always #5 clk = ~clk;

  fixed_div #(
    .WIDTH (32),
    .SCALE (16),
    .LAT   (L)
  ) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .i_valid (i_valid),
    .a       (a),
    .b       (b),
    .o_valid (o_valid),
    .q       (q),
    .o_dz    (o_dz),
    .o_ovf   (o_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] ta, input logic [31:0] tb,
                       input logic [31:0] eq, input bit edz, input bit eovf);
    i_valid  = v;
    a        = ta;
    b        = tb;
    hv[cyc]  = v;
    hq[cyc]  = eq;
    hdz[cyc] = edz;
    hovf[cyc] = eovf;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Advance one clock and compare outputs against the op driven L slots earlier.
  task automatic step();
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= HN) begin
      $display("FAIL history overflow cyc=%0d", cyc);
      $fatal(1);
    end
    if (cyc >= L) begin
      idx = cyc - L;
      check("o_valid", 32'(o_valid), 32'(hv[idx]));
      if (hv[idx]) begin
        check("q", q, hq[idx]);
        check("o_dz", 32'(o_dz), 32'(hdz[idx]));
        check("o_ovf", 32'(o_ovf), 32'(hovf[idx]));
      end
    end
  endtask

  // Reference: signed 64-bit divide truncates toward zero, then saturate.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] mq, output bit mdz, output bit movf);
    longint n, d, r;
    mdz  = 1'b0;
    movf = 1'b0;
    if (mb == 32'h0) begin
      mdz = 1'b1;
      mq  = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      n = longint'($signed(ma)) * 65536;
      d = longint'($signed(mb));
      r = n / d;
      if (r > 64'sd2147483647) begin
        mq = 32'h7FFF_FFFF;
        movf = 1'b1;
      end else if (r < -64'sd2147483648) begin
        mq = 32'h8000_0000;
        movf = 1'b1;
      end else begin
        mq = r[31:0];
      end
    end
  endtask

  task automatic drive_rand(input bit v);
    logic [31:0] ra, rb, eq;
    bit edz, eovf;
    ra = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) ra = -ra;
    if ($urandom_range(0, 31) == 0) ra = 32'h8000_0000;
    rb = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) rb = -rb;
    if ($urandom_range(0, 15) == 0) rb = 32'h0;
    model(ra, rb, eq, edz, eovf);
    drive(v, ra, rb, eq, edz, eovf);
  endtask

  localparam int ND = 11;
  logic [31:0] va  [ND] = '{32'h0001_0000, 32'hFFFD_0000, 32'h0001_0000, 32'h0001_0000,
                            32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_0000,
                            32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [31:0] vb  [ND] = '{32'h0002_0000, 32'h0002_0000, 32'h0003_0000, 32'h0000_0000,
                            32'h0000_0000, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_0100,
                            32'h0001_0000, 32'h0000_8000, 32'h0001_0000};
  logic [31:0] vq  [ND] = '{32'h0000_8000, 32'hFFFE_8000, 32'h0000_5555, 32'h7FFF_FFFF,
                            32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                            32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
  bit          vdz [ND] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
  bit          vov [ND] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0};

  initial begin
    int nops;
    for (int i = 0; i < HN; i++) hv[i] = 1'b0;
    reset_l = 1'b0;
    i_valid = 1'b0;
    a = 32'h0;
    b = 32'h0;
    #2;
    check("rst o_valid", 32'(o_valid), 32'h0);
    check("rst q", q, 32'h0);
    check("rst o_dz", 32'(o_dz), 32'h0);
    check("rst o_ovf", 32'(o_ovf), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_l = 1'b1;

    // Directed vectors, each isolated so o_valid must be a single-cycle pulse.
    for (int i = 0; i < ND; i++) begin
      drive(1'b1, va[i], vb[i], vq[i], vdz[i], vov[i]);
      step();
      idle();
      step();
      idle();
      step();
    end
    repeat (L + 2) step();

    // Random stream with random gaps.
    nops = 0;
    while (nops < 1000) begin
      if ($urandom_range(0, 3) != 0) begin
        drive_rand(1'b1);
        nops++;
      end else begin
        drive_rand(1'b0);
      end
      step();
    end
    idle();
    repeat (L + 2) step();

    // Reset with ops in flight: everything in the pipe is discarded.
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1);
      step();
    end
    idle();
    #1;
    reset_l = 1'b0;
    #1;
    check("async o_valid", 32'(o_valid), 32'h0);
    check("async q", q, 32'h0);
    check("async o_dz", 32'(o_dz), 32'h0);
    check("async o_ovf", 32'(o_ovf), 32'h0);
    for (int i = cyc - L; i <= cyc; i++) if (i >= 0) hv[i] = 1'b0;
    step();
    idle();
    step();
    idle();
    reset_l = 1'b1;
    step();
    drive(1'b1, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 1'b0);
    step();
    idle();
    repeat (L + 2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
